// File: rtl/lag_injection_scheduler_pkg.sv
// Shared types and default sizing for the injection scheduler slice.
// No logic; widths follow the default configuration.
// Backpressure: n/a.
package lag_injection_scheduler_pkg;

    localparam int NUM_DEST      = 4;
    localparam int PACKET_LENGTH = 3;
    localparam int CNT_WIDTH     = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEST_W = idx_width(NUM_DEST);
    localparam int FLIT_W = $clog2(PACKET_LENGTH + 1);

    localparam logic [CNT_WIDTH-1:0] MAX_PENDING = {CNT_WIDTH{1'b1}};

    typedef logic [DEST_W-1:0] dest_idx_t;
    typedef logic [FLIT_W-1:0] flit_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_t;

endpackage

// File: rtl/lag_injection_scheduler_if.sv
// Request and flit-output bundle between traffic generator, scheduler and route stage.
// No logic; slave = scheduler side, master = generator/downstream side.
// Backpressure: req_ready per destination, out_ready on the flit stream.
interface lag_injection_scheduler_if
    import lag_injection_scheduler_pkg::*;
#(
    parameter int num_dest      = NUM_DEST,
    parameter int packet_length = PACKET_LENGTH
);
    localparam int DW = idx_width(num_dest);
    localparam int FW = $clog2(packet_length + 1);

    logic [num_dest-1:0] req_valid;
    logic [num_dest-1:0] req_ready;
    logic                out_ready;
    logic                out_valid;
    logic                out_head;
    logic                out_tail;
    logic [DW-1:0]       out_dest;
    logic [FW-1:0]       out_flit_id;
    logic [31:0]         out_packet_id;
    logic                pending_any;
    logic [31:0]         packets_sent;

    modport slave (
        input  req_valid, out_ready,
        output req_ready, out_valid, out_head, out_tail, out_dest,
               out_flit_id, out_packet_id, pending_any, packets_sent
    );

    modport master (
        output req_valid, out_ready,
        input  req_ready, out_valid, out_head, out_tail, out_dest,
               out_flit_id, out_packet_id, pending_any, packets_sent
    );

endinterface

// File: rtl/lag_rr_arbiter.sv
// Round-robin pick of the first requesting index strictly after the pointer.
// Latency: combinational.
// Backpressure: none; gnt is all-zero when no request is set.
module lag_rr_arbiter
    import lag_injection_scheduler_pkg::*;
#(
    parameter int num_dest = NUM_DEST,
    parameter int DW       = idx_width(num_dest)
) (
    input  logic [num_dest-1:0] req,
    input  logic [DW-1:0]       ptr,
    output logic [num_dest-1:0] gnt,
    output logic [DW-1:0]       gnt_idx
);

    always_comb begin
        int  j;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        // Scan ptr+1 .. ptr+num_dest so the pointer itself has lowest priority.
        for (int k = 1; k <= num_dest; k++) begin
            j = (int'(ptr) + k) % num_dest;
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = DW'(j);
            end
        end
    end

endmodule

// File: rtl/lag_injection_scheduler.sv
// Per-destination pending counters, round-robin grant and head/body/tail flit sequencing.
// Latency: request pulse to first flit valid is 2 cycles; back-to-back packets without bubbles.
// Backpressure: out_ready low holds every output; saturated counters deassert req_ready.
module lag_injection_scheduler
    import lag_injection_scheduler_pkg::*;
#(
    parameter int num_dest      = NUM_DEST,
    parameter int packet_length = PACKET_LENGTH,
    parameter int cnt_width     = CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    lag_injection_scheduler_if.slave bus
);

    localparam int DW = idx_width(num_dest);
    localparam int FW = $clog2(packet_length + 1);

    localparam logic [cnt_width-1:0] CNT_MAX   = {cnt_width{1'b1}};
    localparam logic [cnt_width-1:0] CNT_ONE   = cnt_width'(1);
    localparam logic [FW-1:0]        LAST_FLIT = FW'(packet_length);
    localparam logic [DW-1:0]        LAST_DEST = DW'(num_dest - 1);

    sched_state_t state, state_nxt;

    logic [cnt_width-1:0] cnt [num_dest];
    logic [num_dest-1:0]  ready, accept, dec, arb_req, arb_gnt;
    logic [DW-1:0]        arb_ptr, arb_idx, rr_ptr, out_dest;
    logic [FW-1:0]        flit_id;
    logic                 head, tail;
    logic [31:0]          packet_id, sent;
    logic                 xfer, tail_xfer, start, advance, arb_vld;

    assign xfer      = (state == SEND) && bus.out_ready;
    assign tail_xfer = xfer && tail;

    // The arbiter sees post-decrement counts so the finishing destination
    // only re-wins when it still has another packet queued.
    always_comb begin
        ready   = '0;
        accept  = '0;
        dec     = '0;
        arb_req = '0;
        for (int i = 0; i < num_dest; i++) begin
            ready[i]   = (cnt[i] != CNT_MAX);
            accept[i]  = bus.req_valid[i] && ready[i];
            dec[i]     = tail_xfer && (out_dest == DW'(i));
            arb_req[i] = (cnt[i] != '0) && !(dec[i] && (cnt[i] == CNT_ONE));
        end
    end

    assign arb_ptr = tail_xfer ? out_dest : rr_ptr;
    assign arb_vld = |arb_gnt;

    lag_rr_arbiter #(
        .num_dest (num_dest),
        .DW       (DW)
    ) u_arb (
        .req     (arb_req),
        .ptr     (arb_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < num_dest; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < num_dest; i++) begin
                if (accept[i] && !dec[i])
                    cnt[i] <= cnt[i] + CNT_ONE;
                else if (dec[i] && !accept[i])
                    cnt[i] <= cnt[i] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (arb_vld) begin
                    state_nxt = SEND;
                    start     = 1'b1;
                end
            end
            SEND: begin
                if (tail_xfer) begin
                    if (arb_vld) start     = 1'b1;
                    else         state_nxt = IDLE;
                end else if (xfer) begin
                    advance = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_dest  <= '0;
            flit_id   <= '0;
            head      <= 1'b0;
            tail      <= 1'b0;
            packet_id <= '0;
            sent      <= '0;
            rr_ptr    <= LAST_DEST;
        end else begin
            if (start) begin
                out_dest  <= arb_idx;
                flit_id   <= FW'(1);
                head      <= 1'b1;
                tail      <= (packet_length == 1);
                packet_id <= packet_id + 32'd1;
            end else if (advance) begin
                flit_id <= flit_id + FW'(1);
                head    <= 1'b0;
                tail    <= ((flit_id + FW'(1)) == LAST_FLIT);
            end else if (tail_xfer) begin
                flit_id <= '0;
                head    <= 1'b0;
                tail    <= 1'b0;
            end
            if (tail_xfer) begin
                sent   <= sent + 32'd1;
                rr_ptr <= out_dest;
            end
        end
    end

    always_comb begin
        bus.pending_any = 1'b0;
        for (int i = 0; i < num_dest; i++)
            if (cnt[i] != '0) bus.pending_any = 1'b1;
    end

    assign bus.req_ready     = ready;
    assign bus.out_valid     = (state == SEND);
    assign bus.out_head      = head;
    assign bus.out_tail      = tail;
    assign bus.out_dest      = out_dest;
    assign bus.out_flit_id   = flit_id;
    assign bus.out_packet_id = packet_id;
    assign bus.packets_sent  = sent;

endmodule

// File: doc/lag_injection_scheduler.md
Name: lag_injection_scheduler

Overview:
- Sequences packet injection for one network entry point.
- Keeps a pending-packet count per destination and picks the next destination round-robin.
- Emits the head/body/tail flit sequence of each packet, one flit per accepted handshake.
- Sits between the traffic generator (per-destination packet requests) and the source FIFO / route stage feeding router input 0.

Parameters:
num_dest, 4, number of destinations served (>=1)
packet_length, 3, flits per packet (>=1)
cnt_width, 8, width of each per-destination pending counter (saturates at 2^cnt_width-1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset; asynchronous, active-low
req_valid  input  num_dest  bit i pulse = one new packet for destination i
req_ready  output  num_dest  bit i = counter i below saturation; request accepted only when valid&ready
out_ready  input  1  downstream can take a flit this cycle
out_valid  output  1  a flit is presented
out_head  output  1  presented flit is the head
out_tail  output  1  presented flit is the tail
out_dest  output  $clog2(num_dest) (min 1)  destination index of the current packet
out_flit_id  output  $clog2(packet_length+1)  flit index 1..packet_length
out_packet_id  output  32  running packet number, first packet = 1
pending_any  output  1  OR of all counters non-zero
packets_sent  output  32  count of tails transferred

Behaviour:
- Reset (asynchronous, any cycle including mid-packet) clears:
  - counters; out_valid, out_head, out_tail, out_dest, out_flit_id, out_packet_id and packets_sent all return to 0
  - round-robin pointer = num_dest-1, so destination 0 has first priority
  - a partially sent packet is abandoned; no tail is issued.
- Counter update each cycle, for each i:
  - cnt_i += accept_i - dec_i, where accept_i = req_valid[i]&req_ready[i]
  - dec_i = tail transfer of destination i this cycle
  - simultaneous accept and dec leaves cnt_i unchanged
  - at saturation req_ready[i]=0 and further requests are dropped
  - req_ready is combinational from the registered count.
- FSM states are IDLE and SEND.
  - IDLE: out_valid=0. If any registered cnt_i>0, the arbiter grants the first non-zero i after the pointer (wrapping). Next cycle: SEND, out_dest=grant, out_flit_id=1, out_head=1, out_packet_id++.
  - A request accepted in cycle t is visible to the arbiter at t+1. Minimum latency from req pulse to out_valid is 2 cycles.
  - SEND: out_valid=1, all outputs registered. A transfer occurs when out_valid&out_ready; with no transfer, all outputs hold (stall).
  - Non-tail transfer: out_flit_id++; head clears; tail sets when the new id == packet_length.
  - Tail transfer: packets_sent++, pointer=out_dest, dec applied.
    - If another packet is pending, counting the post-decrement value for out_dest, the next grant is computed in the same cycle. SEND continues back-to-back with a head next cycle, so there is no bubble.
    - Otherwise go to IDLE.
- packet_length=1: every flit has head=tail=1.
- Fairness: with all destinations pending, grants rotate 0,1,...,num_dest-1,0...; a destination never sends two consecutive packets while another is pending.
- out_packet_id and packets_sent wrap modulo 2^32.
- out_valid never depends combinationally on out_ready; out_ready may toggle freely.

Decomposition:
- Shared package holds:
  - dest_idx_t (width $clog2(num_dest))
  - flit_idx_t
  - the sched_state_t enum {IDLE, SEND}
  - MAX_PENDING constant derived from cnt_width
- Sub-module lag_rr_arbiter (num_dest requests, pointer in, one-hot plus encoded grant out, purely combinational) is instantiated once.
- Counters and the FSM stay in the top.

Test Plan:
- Reset, then req_valid=0001 one cycle, out_ready=1:
  - out_valid rises 2 cycles later
  - flits (head,id1,dest0),(id2),(tail,id3)
  - out_packet_id=1, packets_sent=1, then IDLE with pending_any=0.
- req_valid=1111 once, out_ready=1: packets go to dests 0,1,2,3 in order, 12 consecutive valid cycles with no bubble, packets_sent=4.
- Same as the previous case but out_ready low on alternate cycles: each flit is held stable while stalled; order and count are unchanged.
- Hold req_valid[2]=1 for 300 cycles with cnt_width=8 and out_ready=0: counter stops at 255, req_ready[2]=0 from then on, and the excess requests are dropped.
- A req_valid[1] pulse coinciding with dest 1's tail transfer (cnt=1): cnt stays 1 and the next packet is issued to dest 1.
- Assert rst_n=0 during flit 2 of a packet: outputs are 0 immediately and the counters are cleared. After release with no requests, out_valid stays 0.
